uart_xmtr: RTL
==============

# uart_xmtr

Simulation-side UART transmitter that drives serial stimulus into the design's `rs232_uart_rxd` pin, so a bench can feed stdin to the processor. It is the upstream partner of the existing UART receiver wrapper on the `rs232_uart_txd` side. It runs on the same 16x-oversampled baud clock (1.8432 MHz for 115200 baud). Bytes are pushed through a valid/ready port, buffered in a small FIFO, and serialised as 8N1 frames, LSB first.

## Interface

Parameters:
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; legal values are 2 or more.
- `FIFO_DEPTH`, 16, byte FIFO depth; must be a power of 2 and at least 2.

Ports:
- `clock`  in  1  baud oversample clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a byte; high when `fifo_count < FIFO_DEPTH`.
- `uart_sout`  out  1  serial line to the DUT rxd; idle high.
- `busy`  out  1  a frame is in flight or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO.

## Operation

- **Reset values** (registered at the first edge with `reset`=1):
  - `uart_sout`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0.
  - FSM=IDLE; FIFO pointers and the bit/cycle counters are 0.
- **Push.** A byte is accepted on a clock edge where `tx_valid && tx_ready`. `tx_data` is ignored whenever `tx_ready`=0, and there is no overwrite when full.
- **Pop.** The FSM pops the FIFO head when it is in IDLE with the FIFO non-empty, or when it is on the last cycle of STOP with the FIFO non-empty.
- **Push and pop on the same edge:** `fifo_count` is unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- **No bypass.** A byte pushed into an empty FIFO is popped on the following edge, never on the same edge.
- **FSM states:**
  - IDLE: `uart_sout`=1. Goes to START on a pop.
  - START: `uart_sout`=0 for `CLKS_PER_BIT` cycles, then goes to DATA.
  - DATA: `uart_sout` = shift register bit 0 for `CLKS_PER_BIT` cycles per bit. There are 8 bits, LSB first, shifting right after each bit. After bit 7 it goes to STOP.
  - STOP: `uart_sout`=1 for `CLKS_PER_BIT` cycles. At the end it goes to START if it popped, otherwise to IDLE.
- **Counters.**
  - The cycle counter counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - The bit counter counts 0..7 in DATA.
- **`busy`** = (FSM != IDLE) || (`fifo_count` != 0), registered.
- **Reset mid-frame:** the frame is abandoned. `uart_sout` is 1 after the reset edge and the FIFO is emptied. No partial frame resumes after reset deasserts.

## Timing

- All outputs are registered.
- **Latency from idle:** a push on edge N with the FIFO empty and FSM in IDLE gives the following sequence.
  - `fifo_count`=1 after edge N.
  - Pop on edge N+1: `fifo_count`=0 and `uart_sout` falls after edge N+1.
- **Frame length** is exactly 10×`CLKS_PER_BIT` cycles (160 at the default).
- **Back-to-back frames:** the next start bit follows the last stop-bit cycle with zero idle cycles.
- **`tx_ready`** deasserts in the cycle after the edge where `fifo_count` reaches `FIFO_DEPTH`. It reasserts after the edge of the next pop.
- **Push-while-full:** if a push is offered while full and a pop occurs on the same edge, the push is not taken. `tx_ready` was low in that cycle.

## Test plan

- **Single byte.**
  - Stimulus: push 0x55 from idle.
  - Required response:
    - `uart_sout` falls 1 cycle after the accept.
    - The waveform is 0,1,0,1,0,1,0,1,0,1, with each level held 16 cycles.
    - Then the line is idle high, and `busy` drops after 160 cycles.
- **Back-to-back.**
  - Stimulus: push 0xA5 and 0x3C on consecutive edges.
  - Required response:
    - The two frames are contiguous, 320 cycles total.
    - Bits decode LSB-first as 0xA5 then 0x3C.
    - There is no idle-high gap between the STOP of frame 1 and the START of frame 2.
- **Fill.**
  - Stimulus: hold `tx_valid`=1 with an incrementing byte from 0x00.
  - Required response:
    - 17 bytes are accepted; one is popped immediately.
    - `tx_ready`=0 with `fifo_count`=16.
    - `tx_ready` returns to 1 one cycle after the first frame ends.
    - The serial output carries 0x00..0x10 in order, with no loss or duplication.
- **Reset mid-frame.**
  - Stimulus:
    - Push 0xFF and 0x00.
    - Assert `reset` for 1 cycle at cycle 50.
  - Required response:
    - `uart_sout`=1, `fifo_count`=0, `busy`=0 after the reset edge.
    - No further start bit appears within 500 cycles.
- **Parameter variant.**
  - Stimulus: set `CLKS_PER_BIT`=4 and push 0x80.
  - Required response: the frame is 40 cycles, with `uart_sout` high only during bit 7 (cycles 32..35 of the frame) and during the stop bit.
- **Loopback.**
  - Stimulus: connect `uart_sout` to the existing UART receiver wrapper on the same `clock` and push "Hi\n" (0x48, 0x69, 0x0A).
  - Required response: the receiver's output file contains exactly "Hi\n".

Source files
------------

// File: rtl/uart_xmtr.sv
// UART transmitter: bytes enter through a valid/ready port into a small FIFO and leave as
// 8N1 frames, LSB first. Simulation-side stimulus source for a receiver's rxd pin.
module uart_xmtr #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_sout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LastCyc = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   Full    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sout_q, sout_d;
  logic          ready_q, busy_q;
  logic          push, pop, last_cyc;

  assign push     = tx_valid && ready_q;
  assign last_cyc = (cyc_q == LastCyc);
  // The head is only visible once registered, so a fresh byte never bypasses the FIFO.
  assign pop      = (count_q != '0) &&
                    ((state_q == StIdle) || ((state_q == StStop) && last_cyc));

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StStart;
          cyc_d   = '0;
          shift_d = mem[rd_ptr_q];
        end
      end
      StStart: begin
        cyc_d = cyc_q + 1'b1;
        if (last_cyc) begin
          state_d = StData;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      StData: begin
        cyc_d = cyc_q + 1'b1;
        if (last_cyc) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      StStop: begin
        cyc_d = cyc_q + 1'b1;
        if (last_cyc) begin
          cyc_d = '0;
          if (pop) begin
            state_d = StStart;
            shift_d = mem[rd_ptr_q];
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the next state so the registered output lines up with it.
  always_comb begin
    sout_d = 1'b1;
    unique case (state_d)
      StStart: sout_d = 1'b0;
      StData:  sout_d = shift_d[0];
      default: sout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      sout_q   <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sout_q  <= sout_d;
      ready_q <= (count_d < Full);
      busy_q  <= (state_d != StIdle) || (count_d != '0);
    end
  end

  assign tx_ready   = ready_q;
  assign uart_sout  = sout_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule
